// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin bus arbiter with lock hold and h_ready drain.
// Defining ARB_TIMEOUT_EN adds a forced release when h_ready stays low for TIMEOUT_CYCLES cycles.
module bus_arbiter #(
    parameter int MASTER_COUNT   = 2,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [MASTER_COUNT-1:0]         m_req,
    input  logic [MASTER_COUNT-1:0]         m_lock,
    input  logic                            h_ready,
    output logic [MASTER_COUNT-1:0]         m_grant,
    output logic [$clog2(MASTER_COUNT)-1:0] grant_id,
    output logic                            bus_busy,
    output logic                            bus_locked,
    output logic                            arb_timeout
);
    // state | meaning
    // IDLE  | no owner; arbitrate among requesters, bus turnaround cycle
    // GRANT | owner holds the bus while it requests or locks
    // DRAIN | owner released, grant held until the in-flight transfer completes

    localparam int IDW = $clog2(MASTER_COUNT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                  state;
    logic [IDW-1:0]          last_owner;
    logic [IDW-1:0]          winner;
    logic [IDW-1:0]          cand;
    logic                    found;
    logic [MASTER_COUNT-1:0] win_onehot;
    logic                    owner_hold;
    logic                    timeout_hit;

    // Search starts just after the previous owner so it gets lowest priority.
    always_comb begin
        winner     = '0;
        found      = 1'b0;
        cand       = '0;
        win_onehot = '0;
        for (int i = 0; i < MASTER_COUNT; i++) begin
            cand = IDW'((int'(last_owner) + 1 + i) % MASTER_COUNT);
            if (!found && m_req[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
        win_onehot[winner] = 1'b1;
    end

    assign owner_hold = m_req[grant_id] | m_lock[grant_id];

`ifdef ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] tmo_cnt;

    assign timeout_hit = (state != IDLE) && (tmo_cnt == TW'(TIMEOUT_CYCLES));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt     <= '0;
            arb_timeout <= 1'b0;
        end else begin
            arb_timeout <= timeout_hit;
            if (state == IDLE || timeout_hit || h_ready) begin
                tmo_cnt <= '0;
            end else begin
                tmo_cnt <= tmo_cnt + TW'(1);
            end
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign arb_timeout = 1'b0;

    // TIMEOUT_CYCLES only matters when the timeout is built in.
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            m_grant    <= '0;
            grant_id   <= '0;
            bus_busy   <= 1'b0;
            bus_locked <= 1'b0;
            last_owner <= IDW'(MASTER_COUNT - 1);
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        state      <= GRANT;
                        m_grant    <= win_onehot;
                        grant_id   <= winner;
                        bus_busy   <= 1'b1;
                        bus_locked <= m_lock[winner];
                    end
                end
                GRANT: begin
                    if (timeout_hit) begin
                        state      <= IDLE;
                        last_owner <= grant_id;
                        m_grant    <= '0;
                        grant_id   <= '0;
                        bus_busy   <= 1'b0;
                        bus_locked <= 1'b0;
                    end else if (owner_hold) begin
                        bus_locked <= m_lock[grant_id];
                    end else begin
                        last_owner <= grant_id;
                        bus_locked <= 1'b0;
                        if (h_ready) begin
                            state    <= IDLE;
                            m_grant  <= '0;
                            grant_id <= '0;
                            bus_busy <= 1'b0;
                        end else begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (timeout_hit || h_ready) begin
                        state      <= IDLE;
                        m_grant    <= '0;
                        grant_id   <= '0;
                        bus_busy   <= 1'b0;
                        bus_locked <= 1'b0;
                    end
                end
                default: begin
                    state      <= IDLE;
                    m_grant    <= '0;
                    grant_id   <= '0;
                    bus_busy   <= 1'b0;
                    bus_locked <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: a behavioural model predicts each cycle's outputs into a queue,
// a monitor pops and compares. Directed scenarios followed by randomized traffic.
module tb_bus_arbiter;
    localparam int MC  = 3;
    localparam int IW  = $clog2(MC);
    localparam int TMO = 8;
`ifdef ARB_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [MC-1:0] m_req = '0;
    logic [MC-1:0] m_lock = '0;
    logic          h_ready = 1'b1;
    logic [MC-1:0] m_grant;
    logic [IW-1:0] grant_id;
    logic          bus_busy;
    logic          bus_locked;
    logic          arb_timeout;

    bus_arbiter #(.MASTER_COUNT(MC), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .m_req(m_req), .m_lock(m_lock), .h_ready(h_ready),
        .m_grant(m_grant), .grant_id(grant_id), .bus_busy(bus_busy),
        .bus_locked(bus_locked), .arb_timeout(arb_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [MC-1:0] g;
        logic [IW-1:0] id;
        logic          busy;
        logic          locked;
        logic          to;
    } exp_t;

    exp_t exp_q[$];
    int   n_pass  = 0;
    int   n_total = 0;

    // Model state: who owns the bus, who owned it last, whether the owner has let go.
    int owner    = -1;
    int last     = MC - 1;
    int timer    = 0;
    bit draining = 1'b0;
    bit locked   = 1'b0;

    task automatic chk(input string name, input int act, input int req_v);
        n_total++;
        if (act == req_v) n_pass++;
        else $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req_v, $time);
    endtask

    always @(posedge clk) begin : model
        exp_t e;
        bit   to;
        int   c;
        if (!rst_n) begin
            owner = -1; last = MC - 1; timer = 0; draining = 1'b0; locked = 1'b0;
        end else begin
            to = 1'b0;
            if (owner < 0) begin
                if (m_req != '0) begin
                    for (int k = 1; k <= MC; k++) begin
                        c = (last + k) % MC;
                        if (m_req[c]) begin
                            owner = c;
                            break;
                        end
                    end
                    locked = m_lock[owner]; timer = 0; draining = 1'b0;
                end
            end else if (TMO_EN && timer == TMO) begin
                last = owner; owner = -1; locked = 1'b0; draining = 1'b0; to = 1'b1;
            end else if (!draining && (m_req[owner] || m_lock[owner])) begin
                locked = m_lock[owner];
                timer  = h_ready ? 0 : timer + 1;
            end else begin
                if (!draining) begin
                    last = owner; draining = 1'b1; locked = 1'b0;
                end
                if (h_ready) begin
                    owner = -1; draining = 1'b0;
                end else begin
                    timer = timer + 1;
                end
            end
            e.g = '0;
            e.id = '0;
            if (owner >= 0) begin
                e.g[owner] = 1'b1;
                e.id = IW'(owner);
            end
            e.busy   = (owner >= 0);
            e.locked = locked && (owner >= 0);
            e.to     = to;
            exp_q.push_back(e);
        end
    end

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n) begin
                if (exp_q.size() == 0) begin
                    n_total++;
                    $display("FAIL queue_empty actual=0 required=1 at %0t", $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("m_grant", int'(m_grant), int'(e.g));
                    chk("grant_id", int'(grant_id), int'(e.id));
                    chk("bus_busy", int'(bus_busy), int'(e.busy));
                    chk("bus_locked", int'(bus_locked), int'(e.locked));
                    chk("arb_timeout", int'(arb_timeout), int'(e.to));
                end
            end
        end
    end

    task automatic cyc(input logic [MC-1:0] r, input logic [MC-1:0] l, input logic rd, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            m_req = r; m_lock = l; h_ready = rd;
        end
    endtask

    initial begin : stim
        logic [MC-1:0] r;
        logic [MC-1:0] l;
        logic          rd;
        repeat (3) @(negedge clk);
        chk("rst_grant", int'(m_grant), 0);
        chk("rst_grant_id", int'(grant_id), 0);
        chk("rst_busy", int'(bus_busy), 0);
        chk("rst_locked", int'(bus_locked), 0);
        chk("rst_timeout", int'(arb_timeout), 0);
        rst_n = 1'b1;

        // contention straight after reset: master 0 first, then 1 after one idle cycle
        cyc(3'b011, 3'b000, 1'b1, 3);
        cyc(3'b010, 3'b000, 1'b1, 3);
        cyc(3'b000, 3'b000, 1'b1, 2);
        // single requester
        cyc(3'b001, 3'b000, 1'b1, 2);
        cyc(3'b000, 3'b000, 1'b1, 2);
        // lock hold against a competing request, then handover
        cyc(3'b001, 3'b000, 1'b1, 2);
        cyc(3'b010, 3'b001, 1'b1, 10);
        cyc(3'b010, 3'b000, 1'b1, 4);
        cyc(3'b000, 3'b000, 1'b1, 2);
        // drain: release with h_ready low for 3 cycles
        cyc(3'b100, 3'b000, 1'b1, 2);
        cyc(3'b000, 3'b000, 1'b0, 3);
        cyc(3'b000, 3'b000, 1'b1, 2);
        // same master releases and re-requests while another waits
        cyc(3'b001, 3'b000, 1'b1, 2);
        cyc(3'b000, 3'b000, 1'b1, 1);
        cyc(3'b101, 3'b000, 1'b1, 4);
        cyc(3'b000, 3'b000, 1'b1, 2);
        // long stall with request held
        cyc(3'b001, 3'b000, 1'b1, 1);
        cyc(3'b001, 3'b000, 1'b0, 110);
        cyc(3'b000, 3'b000, 1'b1, 3);

        for (int i = 0; i < 3000; i++) begin
            r  = MC'($urandom);
            l  = ($urandom_range(0, 7) == 0) ? MC'($urandom) : '0;
            rd = ($urandom_range(0, 3) != 0);
            if ((i % 250) > 235) rd = 1'b0;
            cyc(r, l, rd, 1);
        end

        // asynchronous reset in the middle of a grant
        cyc(3'b000, 3'b000, 1'b1, 3);
        cyc(3'b100, 3'b000, 1'b1, 2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_grant", int'(m_grant), 0);
        chk("async_rst_busy", int'(bus_busy), 0);
        chk("async_rst_grant_id", int'(grant_id), 0);
        chk("async_rst_locked", int'(bus_locked), 0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(3'b011, 3'b000, 1'b1, 3);
        cyc(3'b000, 3'b000, 1'b1, 3);
        repeat (2) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
